// File: rtl/pe_ws_os_if.sv
// pe_ws_os_if: bundles the per-cell data, weight and control signals of one
// systolic processing element.
//   master : array-side driver (activations, partial sums, weights, control)
//   slave  : the processing element itself
// Ports carried:
//   active, mode, acc_clr, datain, sumin, win, wwrite, wswap   (towards PE)
//   maccout, dataout, wout, wwriteout, wswapout, activeout, ovf (from PE)
interface pe_ws_os_if #(
    parameter int DATA_W = 8,
    parameter int W_W    = 8,
    parameter int ACC_W  = 16
);
    logic                     active;
    logic                     mode;
    logic                     acc_clr;
    logic signed [DATA_W-1:0] datain;
    logic signed [ACC_W-1:0]  sumin;
    logic signed [W_W-1:0]    win;
    logic                     wwrite;
    logic                     wswap;
    logic signed [ACC_W-1:0]  maccout;
    logic signed [DATA_W-1:0] dataout;
    logic signed [W_W-1:0]    wout;
    logic                     wwriteout;
    logic                     wswapout;
    logic                     activeout;
    logic                     ovf;

    modport master (
        output active, mode, acc_clr, datain, sumin, win, wwrite, wswap,
        input  maccout, dataout, wout, wwriteout, wswapout, activeout, ovf
    );

    modport slave (
        input  active, mode, acc_clr, datain, sumin, win, wwrite, wswap,
        output maccout, dataout, wout, wwriteout, wswapout, activeout, ovf
    );
endinterface

// File: rtl/pe_ws_os.sv
// pe_ws_os: parametrised systolic MAC cell with double-buffered weights.
// Runs weight-stationary (mode=0, partial sum arrives on sumin) or
// output-stationary (mode=1, sum accumulates in place).
// Ports:
//   clock        rising-edge clock
//   rst_n        asynchronous active-low reset, clears every register
//   bus (slave)  pe_ws_os_if: data/weight/control in, registered results out
// Configuration macro:
//   PE_SAT_EN    defined   -> saturating additions, sticky ovf flag
//                undefined -> additions wrap modulo 2^ACC_W, ovf tied to 0
module pe_ws_os #(
    parameter int DATA_W = 8,
    parameter int W_W    = 8,
    parameter int ACC_W  = 16
) (
    input  logic          clock,
    input  logic          rst_n,
    pe_ws_os_if.slave     bus
);
    localparam int PROD_W = DATA_W + W_W;

    logic signed [W_W-1:0]    shadow_w_r;
    logic signed [W_W-1:0]    act_w_r;
    logic signed [DATA_W-1:0] dataout_r;
    logic signed [ACC_W-1:0]  macc_r;
    logic signed [ACC_W-1:0]  macc_next_s;
    logic signed [ACC_W-1:0]  addend_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic                     wwrite_r;
    logic                     wswap_r;
    logic                     active_r;

`ifdef PE_SAT_EN
    // One guard bit above the accumulator exposes signed overflow.
    logic [ACC_W:0]           sum_s;
    logic                     add_hit_s;
    logic                     ovf_next_s;
    logic                     ovf_r;

    // True when the guard bit disagrees with the accumulator sign bit.
    function automatic logic sum_overflows(input logic [ACC_W:0] s);
        return s[ACC_W] ^ s[ACC_W-1];
    endfunction

    // Clamp an overflowed sum to the extreme of the sign indicated by the guard bit.
    function automatic logic [ACC_W-1:0] sat_clamp(input logic [ACC_W:0] s);
        logic [ACC_W-1:0] r;
        if (sum_overflows(s)) begin
            r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            r = s[ACC_W-1:0];
        end
        return r;
    endfunction
`else
    logic signed [ACC_W-1:0]  sum_s;
`endif

    // Full-precision product against the active weight, sign-extended, and the adder.
    always_comb begin
        prod_s     = PROD_W'(bus.datain) * PROD_W'(act_w_r);
        prod_ext_s = ACC_W'(prod_s);
        addend_s   = bus.mode ? macc_r : bus.sumin;
`ifdef PE_SAT_EN
        sum_s      = {addend_s[ACC_W-1], addend_s} + {prod_ext_s[ACC_W-1], prod_ext_s};
`else
        sum_s      = addend_s + prod_ext_s;
`endif
    end

    // Next accumulator value: compute when active, hold (or OS clear) when stalled.
    always_comb begin
        macc_next_s = macc_r;
`ifdef PE_SAT_EN
        add_hit_s   = 1'b0;
`endif
        if (bus.active) begin
            if (bus.mode && bus.acc_clr) begin
                macc_next_s = prod_ext_s;
            end else begin
`ifdef PE_SAT_EN
                macc_next_s = sat_clamp(sum_s);
                add_hit_s   = sum_overflows(sum_s);
`else
                macc_next_s = sum_s;
`endif
            end
        end else begin
            if (bus.mode && bus.acc_clr) begin
                macc_next_s = {ACC_W{1'b0}};
            end else begin
                macc_next_s = macc_r;
            end
        end
    end

    // Data-path registers: accumulator and activation pass-through.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            macc_r    <= {ACC_W{1'b0}};
            dataout_r <= {DATA_W{1'b0}};
        end else begin
            macc_r <= macc_next_s;
            if (bus.active) begin
                dataout_r <= bus.datain;
            end
        end
    end

    // Double-buffered weights; a simultaneous write and swap moves the pre-write shadow.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            shadow_w_r <= {W_W{1'b0}};
            act_w_r    <= {W_W{1'b0}};
        end else begin
            if (bus.wwrite) begin
                shadow_w_r <= bus.win;
            end
            if (bus.wswap) begin
                act_w_r <= shadow_w_r;
            end
        end
    end

    // One-cycle delayed control copies that ripple to the neighbouring cells.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wwrite_r <= 1'b0;
            wswap_r  <= 1'b0;
            active_r <= 1'b0;
        end else begin
            wwrite_r <= bus.wwrite;
            wswap_r  <= bus.wswap;
            active_r <= bus.active;
        end
    end

`ifdef PE_SAT_EN
    // acc_clr takes precedence over a same-cycle overflow.
    assign ovf_next_s = bus.acc_clr ? 1'b0 : (ovf_r | add_hit_s);

    // Sticky saturation flag.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_next_s;
        end
    end

    assign bus.ovf = ovf_r;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.maccout   = macc_r;
    assign bus.dataout   = dataout_r;
    assign bus.wout      = shadow_w_r;
    assign bus.wwriteout = wwrite_r;
    assign bus.wswapout  = wswap_r;
    assign bus.activeout = active_r;
endmodule

// File: tb/tb_pe_ws_os.sv
// tb_pe_ws_os: directed and randomized checks of pe_ws_os against an
// arithmetic reference model. A column of three cells (top = u_dut) shares
// all control; win of each lower cell is the wout of the cell above.
module tb_pe_ws_os;
    localparam int DATA_W = 8;
    localparam int W_W    = 8;
    localparam int ACC_W  = 16;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));

    logic clock = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    pe_ws_os_if #(.DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W)) bus   ();
    pe_ws_os_if #(.DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W)) bus_m ();
    pe_ws_os_if #(.DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W)) bus_b ();

    assign bus_m.active  = bus.active;
    assign bus_m.mode    = bus.mode;
    assign bus_m.acc_clr = bus.acc_clr;
    assign bus_m.datain  = bus.datain;
    assign bus_m.sumin   = bus.sumin;
    assign bus_m.win     = bus.wout;
    assign bus_m.wwrite  = bus.wwrite;
    assign bus_m.wswap   = bus.wswap;
    assign bus_b.active  = bus.active;
    assign bus_b.mode    = bus.mode;
    assign bus_b.acc_clr = bus.acc_clr;
    assign bus_b.datain  = bus.datain;
    assign bus_b.sumin   = bus.sumin;
    assign bus_b.win     = bus_m.wout;
    assign bus_b.wwrite  = bus.wwrite;
    assign bus_b.wswap   = bus.wswap;

    pe_ws_os #(.DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W)) u_dut (.clock(clock), .rst_n(rst_n), .bus(bus));
    pe_ws_os #(.DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W)) u_mid (.clock(clock), .rst_n(rst_n), .bus(bus_m));
    pe_ws_os #(.DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W)) u_bot (.clock(clock), .rst_n(rst_n), .bus(bus_b));

    // Free-running clock.
    always #5 clock = ~clock;

    // Reference model state: top cell datapath plus the weight pair of all three cells.
    longint m_macc;
    int     m_data;
    int     m_sh [3];
    int     m_ac [3];
    bit     m_ovf, m_wwo, m_wso, m_aco;
    bit     mac_valid = 1'b1;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        longint m;
        longint r;
        m = longint'(1) <<< ACC_W;
        r = v % m;
        if (r < 0) r += m;
        if (r > ACC_MAX) r -= m;
        return r;
    endfunction

    task automatic model_reset();
        m_macc = 0; m_data = 0; m_ovf = 0; m_wwo = 0; m_wso = 0; m_aco = 0;
        for (int i = 0; i < 3; i++) begin
            m_sh[i] = 0;
            m_ac[i] = 0;
        end
    endtask

    // Apply the cell rules to the inputs currently driven (called just before an edge).
    task automatic model_step();
        longint prod;
        longint s;
        bit     hit;
        int     nsh [3];
        hit  = 1'b0;
        prod = longint'(bus.datain) * longint'(m_ac[0]);
        if (bus.active) begin
            if (bus.mode && bus.acc_clr) begin
                s = prod;
            end else begin
                s = (bus.mode ? m_macc : longint'(bus.sumin)) + prod;
`ifdef PE_SAT_EN
                if (s > ACC_MAX) begin s = ACC_MAX; hit = 1'b1; end
                else if (s < ACC_MIN) begin s = ACC_MIN; hit = 1'b1; end
`else
                s = wrap_acc(s);
`endif
            end
            m_macc = s;
            m_data = int'(bus.datain);
        end else if (bus.mode && bus.acc_clr) begin
            m_macc = 0;
        end
        m_ovf = bus.acc_clr ? 1'b0 : (m_ovf | hit);
        for (int i = 0; i < 3; i++) begin
            if (bus.wwrite) nsh[i] = (i == 0) ? int'(bus.win) : m_sh[i-1];
            else nsh[i] = m_sh[i];
            if (bus.wswap) m_ac[i] = m_sh[i];
        end
        for (int i = 0; i < 3; i++) m_sh[i] = nsh[i];
        m_wwo = bus.wwrite;
        m_wso = bus.wswap;
        m_aco = bus.active;
    endtask

    task automatic compare_all();
        if (mac_valid) begin
            chk("maccout", bus.maccout, m_macc);
            chk("ovf", {63'd0, bus.ovf}, {63'd0, m_ovf});
        end else begin
            chk("macc_no_x", {63'd0, $isunknown(bus.maccout)}, 64'sd0);
        end
        chk("dataout", bus.dataout, m_data);
        chk("wout_top", bus.wout, m_sh[0]);
        chk("wout_mid", bus_m.wout, m_sh[1]);
        chk("wout_bot", bus_b.wout, m_sh[2]);
        chk("wwriteout", {63'd0, bus.wwriteout}, {63'd0, m_wwo});
        chk("wswapout", {63'd0, bus.wswapout}, {63'd0, m_wso});
        chk("activeout", {63'd0, bus.activeout}, {63'd0, m_aco});
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic load_act(input int w);
        bus.win = W_W'(w);
        bus.wwrite = 1'b1;
        tick();
        bus.wwrite = 1'b0;
        bus.wswap = 1'b1;
        tick();
        bus.wswap = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_macc", bus.maccout, 64'sd0);
        compare_all();
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.active = 1'b0; bus.mode = 1'b0; bus.acc_clr = 1'b0;
        bus.datain = '0; bus.sumin = '0; bus.win = '0;
        bus.wwrite = 1'b0; bus.wswap = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(negedge clock);
        rst_n = 1'b1;
        tick();

        // Column preload: first weight ends at the bottom.
        bus.wwrite = 1'b1;
        bus.win = 8'sd5; tick();
        bus.win = 8'sd6; tick();
        bus.win = 8'sd7; tick();
        bus.wwrite = 1'b0;
        chk("pre_wout_bot", bus_b.wout, 64'sd5);
        chk("pre_wout_mid", bus_m.wout, 64'sd6);
        chk("pre_wout_top", bus.wout, 64'sd7);
        bus.wswap = 1'b1; tick(); bus.wswap = 1'b0;
        bus.active = 1'b1; bus.datain = 8'sd1; bus.sumin = 16'sd0;
        tick();
        chk("pre_act_top", bus.maccout, 64'sd7);
        chk("pre_act_mid", bus_m.maccout, 64'sd6);
        chk("pre_act_bot", bus_b.maccout, 64'sd5);
        bus.active = 1'b0;
        bus.wwrite = 1'b1; bus.win = 8'sd2; tick();
        bus.wswap = 1'b1; bus.win = 8'sd9; tick();
        bus.wwrite = 1'b0; bus.wswap = 1'b0;
        chk("joint_wout", bus.wout, 64'sd9);
        bus.active = 1'b1;
        tick();
        chk("joint_act_top", bus.maccout, 64'sd2);
        chk("joint_act_mid", bus_m.maccout, 64'sd7);
        chk("joint_act_bot", bus_b.maccout, 64'sd6);
        bus.active = 1'b0;

        // Weight-stationary MAC and stall hold.
        load_act(3);
        bus.active = 1'b1; bus.datain = -8'sd4; bus.sumin = 16'sd100;
        tick();
        chk("ws_macc", bus.maccout, 64'sd88);
        bus.active = 1'b0; bus.datain = 8'sd7; bus.sumin = 16'sd5;
        tick();
        chk("ws_hold_macc", bus.maccout, 64'sd88);
        chk("ws_hold_data", bus.dataout, -64'sd4);

        // Output-stationary accumulation and stalled clear.
        bus.mode = 1'b1;
        load_act(2);
        bus.active = 1'b1; bus.acc_clr = 1'b1; bus.datain = 8'sd1; tick();
        chk("os_acc1", bus.maccout, 64'sd2);
        bus.acc_clr = 1'b0; bus.datain = 8'sd2; tick();
        chk("os_acc2", bus.maccout, 64'sd6);
        bus.datain = 8'sd3; tick();
        chk("os_acc3", bus.maccout, 64'sd12);
        bus.active = 1'b0; bus.acc_clr = 1'b1; tick();
        chk("os_clr_idle", bus.maccout, 64'sd0);
        bus.acc_clr = 1'b0; tick();

        // Overflow at the positive edge of the accumulator range.
        bus.mode = 1'b0;
        load_act(10);
        bus.active = 1'b1; bus.sumin = 16'sd32760; bus.datain = 8'sd10;
        tick();
`ifdef PE_SAT_EN
        chk("sat_macc", bus.maccout, 64'sd32767);
        chk("sat_ovf", {63'd0, bus.ovf}, 64'sd1);
`else
        chk("wrap_macc", bus.maccout, -64'sd32676);
        chk("wrap_ovf", {63'd0, bus.ovf}, 64'sd0);
`endif
        bus.active = 1'b0; tick(); tick();
        bus.acc_clr = 1'b1; tick();
        chk("ovf_cleared", {63'd0, bus.ovf}, 64'sd0);
        bus.acc_clr = 1'b0;

        // Swap timing with streaming data.
        bus.win = -8'sd3; bus.wwrite = 1'b1; tick(); bus.wwrite = 1'b0;
        bus.active = 1'b1; bus.sumin = 16'sd0; bus.datain = 8'sd1; bus.wswap = 1'b1;
        tick();
        chk("swap_old_w", bus.maccout, 64'sd10);
        chk("swap_out_hi", {63'd0, bus.wswapout}, 64'sd1);
        bus.wswap = 1'b0;
        tick();
        chk("swap_new_w", bus.maccout, -64'sd3);
        chk("swap_out_lo", {63'd0, bus.wswapout}, 64'sd0);

        // Asynchronous reset in the middle of an OS accumulation.
        bus.active = 1'b0; tick();
        bus.mode = 1'b1; bus.active = 1'b1; bus.acc_clr = 1'b1; bus.datain = 8'sd5; tick();
        bus.acc_clr = 1'b0; tick();
        async_reset();
        bus.active = 1'b0; tick();

        // Randomized traffic; mode only changes on stalled cycles.
        for (int n = 0; n < 600; n++) begin
            bus.active  = ($urandom_range(3) != 0);
            if (!bus.active && $urandom_range(2) == 0) bus.mode = ~bus.mode;
            bus.acc_clr = ($urandom_range(7) == 0);
            bus.datain  = DATA_W'($urandom);
            bus.win     = W_W'($urandom);
            bus.wwrite  = ($urandom_range(2) == 0);
            bus.wswap   = ($urandom_range(4) == 0);
            if ($urandom_range(3) == 0) bus.sumin = ACC_W'(ACC_MAX - longint'($urandom_range(300)));
            else if ($urandom_range(3) == 0) bus.sumin = ACC_W'(ACC_MIN + longint'($urandom_range(300)));
            else bus.sumin = ACC_W'($urandom);
            tick();
        end

        // Mode flips while active: value unspecified, but must not be X.
        mac_valid = 1'b0;
        bus.active = 1'b1; bus.acc_clr = 1'b0;
        for (int n = 0; n < 4; n++) begin
            bus.mode = ~bus.mode;
            tick();
        end
        async_reset();
        mac_valid = 1'b1;
        bus.active = 1'b0; bus.wwrite = 1'b0; bus.wswap = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
